rv_trace_buffer: RTL and testbench

- Synthesizable execution-trace capture block for the RV32I core, the hardware successor to per-cycle PC/ALU/DMem printing in simulation.
- Records one entry per cycle (PC, ALU result, data-memory read word) into a circular buffer of parametrised depth.
- Stops on a PC-match trigger followed by a programmable number of post-trigger entries.
- Captured history is read back by logical index (oldest first) via a registered read port, usable from a bench or a debug bus.

---
 rtl/rv_trace_buffer.sv | 124 ++++++++++++
 tb/tb_rv_trace_buffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv_trace_buffer.sv
// rtl/rv_trace_buffer.sv - circular execution-trace capture buffer with PC-match trigger
// Records {pc, alu, mem} per valid cycle and freezes post_cnt entries after the trigger.
module rv_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            top_clk,
  input  logic            top_rst,
  input  logic            cap_valid,
  input  logic [XLEN-1:0] cap_pc,
  input  logic [XLEN-1:0] cap_alu,
  input  logic [XLEN-1:0] cap_mem,
  input  logic            arm,
  input  logic            trig_en,
  input  logic [XLEN-1:0] trig_pc,
  input  logic [AW-1:0]   post_cnt,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_idx,
  output logic [XLEN-1:0] rd_pc,
  output logic [XLEN-1:0] rd_alu,
  output logic [XLEN-1:0] rd_mem,
  output logic            rd_valid,
  output logic [1:0]      state,
  output logic [AW:0]     fill_count,
  output logic [AW-1:0]   trig_idx
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [3*XLEN-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr, remaining, post_taken, post_taken_inc, rd_phys;
  logic [AW:0]       fill_inc;
  logic              we, trig_hit, rd_hit;

  assign state = state_q;

  always_comb begin
    we             = !top_rst && cap_valid && !arm && (state_q == S_ARMED || state_q == S_POST);
    trig_hit       = trig_en && (cap_pc == trig_pc);
    fill_inc       = (fill_count == (AW+1)'(DEPTH)) ? fill_count : fill_count + (AW+1)'(1);
    post_taken_inc = post_taken + AW'(1);
    // Oldest valid entry sits fill_count slots behind the write pointer.
    rd_phys        = wr_ptr - fill_count[AW-1:0] + rd_idx;
    rd_hit         = ({1'b0, rd_idx} < fill_count);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arm) state_d = S_ARMED;
      S_ARMED: begin
        if (arm) state_d = S_ARMED;
        else if (we && trig_hit) state_d = (post_cnt == '0) ? S_DONE : S_POST;
      end
      S_POST: begin
        if (arm) state_d = S_ARMED;
        else if (we && remaining == AW'(1)) state_d = S_DONE;
      end
      S_DONE:  if (arm) state_d = S_ARMED;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge top_clk) begin
    if (top_rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // post_cnt is AW bits wide, so sampling it already bounds it to DEPTH-1.
  always_ff @(posedge top_clk) begin
    if (top_rst) begin
      wr_ptr     <= '0;
      fill_count <= '0;
      trig_idx   <= '0;
      remaining  <= '0;
      post_taken <= '0;
    end else if (arm) begin
      wr_ptr     <= '0;
      fill_count <= '0;
      remaining  <= '0;
      post_taken <= '0;
    end else if (we) begin
      wr_ptr     <= wr_ptr + AW'(1);
      fill_count <= fill_inc;
      if (state_q == S_ARMED && trig_hit) begin
        remaining  <= post_cnt;
        post_taken <= '0;
        if (post_cnt == '0) trig_idx <= fill_inc[AW-1:0] - AW'(1);
      end else if (state_q == S_POST) begin
        remaining  <= remaining - AW'(1);
        post_taken <= post_taken_inc;
        if (remaining == AW'(1)) trig_idx <= fill_inc[AW-1:0] - AW'(1) - post_taken_inc;
      end
    end
  end

  always_ff @(posedge top_clk) begin
    if (we) mem_q[wr_ptr] <= {cap_pc, cap_alu, cap_mem};
  end

  always_ff @(posedge top_clk) begin
    if (top_rst) begin
      rd_valid <= 1'b0;
      rd_pc    <= '0;
      rd_alu   <= '0;
      rd_mem   <= '0;
    end else if (rd_en) begin
      rd_valid <= rd_hit;
      if (rd_hit) {rd_pc, rd_alu, rd_mem} <= mem_q[rd_phys];
      else        {rd_pc, rd_alu, rd_mem} <= '0;
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv_trace_buffer.sv
// tb/tb_rv_trace_buffer.sv - self-checking bench for rv_trace_buffer
// Reference model keeps the last DEPTH captured entries in a queue, oldest first.
module tb_rv_trace_buffer;
  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic            top_clk = 1'b0;
  logic            top_rst, cap_valid, arm, trig_en, rd_en;
  logic [XLEN-1:0] cap_pc, cap_alu, cap_mem, trig_pc;
  logic [AW-1:0]   post_cnt, rd_idx;
  logic [XLEN-1:0] rd_pc, rd_alu, rd_mem;
  logic            rd_valid;
  logic [1:0]      state;
  logic [AW:0]     fill_count;
  logic [AW-1:0]   trig_idx;

  int checks = 0;
  int errors = 0;

  logic [3*XLEN-1:0] hist[$];
  int              m_state, m_rem, n_wr, trig_serial;
  logic            m_rdv;
  logic [XLEN-1:0] m_pc, m_alu, m_mem;
  logic [AW-1:0]   m_trig;

  always #5 top_clk = ~top_clk;

  rv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .top_clk(top_clk), .top_rst(top_rst), .cap_valid(cap_valid), .cap_pc(cap_pc),
    .cap_alu(cap_alu), .cap_mem(cap_mem), .arm(arm), .trig_en(trig_en),
    .trig_pc(trig_pc), .post_cnt(post_cnt), .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_pc(rd_pc), .rd_alu(rd_alu), .rd_mem(rd_mem), .rd_valid(rd_valid),
    .state(state), .fill_count(fill_count), .trig_idx(trig_idx)
  );

  // One clock: model consumes the inputs seen at the edge, then returns on the falling edge.
  task automatic tick();
    int fill;
    @(posedge top_clk);
    fill = hist.size();
    if (top_rst) begin
      m_state = 0; hist.delete(); n_wr = 0; m_rdv = 0;
      m_pc = '0; m_alu = '0; m_mem = '0; m_trig = '0;
    end else begin
      if (rd_en) begin
        if (int'(rd_idx) < fill) begin m_rdv = 1; {m_pc, m_alu, m_mem} = hist[rd_idx]; end
        else begin m_rdv = 0; m_pc = '0; m_alu = '0; m_mem = '0; end
      end else m_rdv = 0;
      if (arm) begin
        m_state = 1; hist.delete(); n_wr = 0;
      end else if (cap_valid && (m_state == 1 || m_state == 2)) begin
        hist.push_back({cap_pc, cap_alu, cap_mem});
        if (hist.size() > DEPTH) void'(hist.pop_front());
        n_wr++;
        if (m_state == 1) begin
          if (trig_en && cap_pc == trig_pc) begin
            trig_serial = n_wr - 1;
            if (post_cnt == 0) m_state = 3;
            else begin m_state = 2; m_rem = int'(post_cnt); end
          end
        end else begin
          m_rem--;
          if (m_rem == 0) m_state = 3;
        end
        if (m_state == 3) m_trig = AW'(trig_serial - (n_wr - hist.size()));
      end
    end
    @(negedge top_clk);
  endtask

  task automatic cap(input logic [XLEN-1:0] pc);
    cap_valid = 1; cap_pc = pc; cap_alu = $urandom; cap_mem = $urandom;
    tick();
    cap_valid = 0;
  endtask

  task automatic rd(input int idx);
    rd_en = 1; rd_idx = AW'(idx);
    tick();
    rd_en = 0;
  endtask

  task automatic do_arm();
    arm = 1; tick(); arm = 0;
  endtask

  task automatic test_reset();
    top_rst = 1; tick(); tick(); top_rst = 0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (fill_count !== 4'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", fill_count); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0b exp 0", rd_valid); end
    checks++; if (rd_pc !== 32'd0) begin errors++; $display("FAIL reset_rd_pc got %h exp 0", rd_pc); end
    cap(32'h0);
    checks++; if (fill_count !== 4'd0) begin errors++; $display("FAIL idle_no_write got %0d exp 0", fill_count); end
  endtask

  task automatic test_capture();
    trig_en = 0;
    do_arm();
    for (int i = 0; i < 5; i++) cap(32'(4 * i));
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL cap_state got %0d exp 1", state); end
    checks++; if (fill_count !== 4'd5) begin errors++; $display("FAIL cap_fill got %0d exp 5", fill_count); end
    for (int i = 0; i < 6; i++) begin
      rd(i);
      checks++; if (rd_valid !== (i < 5)) begin errors++; $display("FAIL cap_rd_valid idx %0d got %0b exp %0b", i, rd_valid, i < 5); end
      checks++; if (rd_pc !== ((i < 5) ? 32'(4 * i) : 32'd0)) begin errors++; $display("FAIL cap_rd_pc idx %0d got %h", i, rd_pc); end
      checks++; if ({rd_alu, rd_mem} !== {m_alu, m_mem}) begin errors++; $display("FAIL cap_rd_data idx %0d got %h %h exp %h %h", i, rd_alu, rd_mem, m_alu, m_mem); end
    end
    rd(2); tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_drop got %0b exp 0", rd_valid); end
    checks++; if (rd_pc !== 32'h8) begin errors++; $display("FAIL rd_hold got %h exp 8", rd_pc); end
  endtask

  task automatic test_wrap();
    trig_en = 0;
    do_arm();
    for (int i = 0; i < 12; i++) cap(32'(4 * i));
    checks++; if (fill_count !== 4'd8) begin errors++; $display("FAIL wrap_fill got %0d exp 8", fill_count); end
    for (int i = 0; i < 8; i++) begin
      rd(i);
      checks++; if (rd_valid !== 1'b1 || rd_pc !== 32'(16 + 4 * i)) begin errors++; $display("FAIL wrap_rd idx %0d got %b %h exp 1 %h", i, rd_valid, rd_pc, 16 + 4 * i); end
      checks++; if ({rd_alu, rd_mem} !== {m_alu, m_mem}) begin errors++; $display("FAIL wrap_rd_data idx %0d got %h %h", i, rd_alu, rd_mem); end
    end
  endtask

  task automatic test_trigger();
    trig_en = 1; trig_pc = 32'h20; post_cnt = 3'd3;
    do_arm();
    for (int i = 0; i < 16; i++) begin
      cap(32'(4 * i));
      checks++; if (state !== ((i >= 11) ? 2'd3 : (i >= 8) ? 2'd2 : 2'd1)) begin errors++; $display("FAIL trig_state after pc %h got %0d", 4 * i, state); end
    end
    checks++; if (fill_count !== 4'd8) begin errors++; $display("FAIL trig_fill got %0d exp 8", fill_count); end
    checks++; if (trig_idx !== 3'd4) begin errors++; $display("FAIL trig_idx got %0d exp 4", trig_idx); end
    rd(4);
    checks++; if (rd_pc !== 32'h20) begin errors++; $display("FAIL trig_rd4 got %h exp 20", rd_pc); end
    rd(7);
    checks++; if (rd_pc !== 32'h2C) begin errors++; $display("FAIL trig_rd7 got %h exp 2c", rd_pc); end
  endtask

  task automatic test_post_bounds();
    trig_en = 1; trig_pc = 32'h08; post_cnt = 3'd0;
    do_arm();
    for (int i = 0; i < 3; i++) cap(32'(4 * i));
    checks++; if (state !== 2'd3 || fill_count !== 4'd3) begin errors++; $display("FAIL post0 got state %0d fill %0d exp 3 3", state, fill_count); end
    checks++; if (trig_idx !== 3'd2) begin errors++; $display("FAIL post0_trig_idx got %0d exp 2", trig_idx); end
    trig_pc = 32'h00; post_cnt = 3'd7;
    do_arm();
    for (int i = 0; i < 10; i++) cap(32'(4 * i));
    checks++; if (state !== 2'd3 || fill_count !== 4'd8) begin errors++; $display("FAIL post7 got state %0d fill %0d exp 3 8", state, fill_count); end
    checks++; if (trig_idx !== 3'd0) begin errors++; $display("FAIL post7_trig_idx got %0d exp 0", trig_idx); end
    rd(0);
    checks++; if (rd_pc !== 32'h0 || rd_valid !== 1'b1) begin errors++; $display("FAIL post7_rd0 got %b %h exp 1 0", rd_valid, rd_pc); end
  endtask

  task automatic test_collision();
    trig_en = 1; trig_pc = 32'h04; post_cnt = 3'd5;
    arm = 1; cap_valid = 1; cap_pc = 32'h40; tick(); arm = 0; cap_valid = 0;
    checks++; if (state !== 2'd1 || fill_count !== 4'd0) begin errors++; $display("FAIL arm_cap got state %0d fill %0d exp 1 0", state, fill_count); end
    cap(32'h0); cap(32'h4);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL to_post got %0d exp 2", state); end
    arm = 1; cap_valid = 1; cap_pc = 32'h8; tick(); arm = 0; cap_valid = 0;
    checks++; if (state !== 2'd1 || fill_count !== 4'd0) begin errors++; $display("FAIL rearm_post got state %0d fill %0d exp 1 0", state, fill_count); end
  endtask

  task automatic test_reset_mid();
    trig_en = 1; trig_pc = 32'h04; post_cnt = 3'd5;
    do_arm();
    cap(32'h0); cap(32'h4); cap(32'h8);
    rd(0);
    top_rst = 1; rd_en = 1; rd_idx = '0; tick(); top_rst = 0; rd_en = 0;
    checks++; if (state !== 2'd0 || fill_count !== 4'd0) begin errors++; $display("FAIL rst_mid got state %0d fill %0d exp 0 0", state, fill_count); end
    checks++; if (rd_valid !== 1'b0 || rd_pc !== 32'd0) begin errors++; $display("FAIL rst_mid_rd got %b %h exp 0 0", rd_valid, rd_pc); end
    cap(32'h0); cap(32'h4);
    checks++; if (state !== 2'd0 || fill_count !== 4'd0) begin errors++; $display("FAIL rst_mid_ignore got state %0d fill %0d exp 0 0", state, fill_count); end
  endtask

  task automatic test_random();
    int errs0;
    errs0 = errors;
    do_arm();
    for (int c = 0; c < 1500; c++) begin
      top_rst   = ($urandom_range(0, 199) == 0);
      arm       = ($urandom_range(0, 39) == 0);
      cap_valid = ($urandom_range(0, 9) < 7);
      cap_pc    = 32'($urandom_range(0, 15) * 4);
      cap_alu   = $urandom; cap_mem = $urandom;
      trig_en   = ($urandom_range(0, 3) != 0);
      trig_pc   = 32'($urandom_range(0, 15) * 4);
      post_cnt  = AW'($urandom_range(0, 7));
      rd_en     = $urandom_range(0, 1);
      rd_idx    = AW'($urandom_range(0, 7));
      tick();
      if (m_state == 0 && $urandom_range(0, 3) == 0) begin top_rst = 0; do_arm(); end
      checks++; if (state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state cyc %0d got %0d exp %0d", c, state, m_state); end
      checks++; if (fill_count !== (AW+1)'(hist.size())) begin errors++; $display("FAIL rnd_fill cyc %0d got %0d exp %0d", c, fill_count, hist.size()); end
      checks++; if (rd_valid !== m_rdv) begin errors++; $display("FAIL rnd_rd_valid cyc %0d got %b exp %b", c, rd_valid, m_rdv); end
      checks++; if ({rd_pc, rd_alu, rd_mem} !== {m_pc, m_alu, m_mem}) begin errors++; $display("FAIL rnd_rd_data cyc %0d got %h %h %h exp %h %h %h", c, rd_pc, rd_alu, rd_mem, m_pc, m_alu, m_mem); end
      if (m_state == 3) begin
        checks++; if (trig_idx !== m_trig) begin errors++; $display("FAIL rnd_trig_idx cyc %0d got %0d exp %0d", c, trig_idx, m_trig); end
      end
      if (errors - errs0 > 10) break;
    end
    top_rst = 0; arm = 0; cap_valid = 0; rd_en = 0;
  endtask

  initial begin
    top_rst = 1; cap_valid = 0; arm = 0; trig_en = 0; rd_en = 0;
    cap_pc = '0; cap_alu = '0; cap_mem = '0; trig_pc = '0; post_cnt = '0; rd_idx = '0;
    m_state = 0; m_rem = 0; n_wr = 0; trig_serial = 0; m_rdv = 0;
    m_pc = '0; m_alu = '0; m_mem = '0; m_trig = '0;
    test_reset();
    test_capture();
    test_wrap();
    test_trigger();
    test_post_bounds();
    test_collision();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
